// File: rtl/i_sram_like_bridge_nw.sv
// Instruction-side sram to sram-like bridge returning up to FETCH_N words per beat.
// Optional performance counters are enabled with the I_BRIDGE_PERF_EN macro.
module i_sram_like_bridge_nw #(
  parameter int unsigned FETCH_N = 2,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    inst_sram_en,
  input  logic [ADDR_W-1:0]       inst_sram_addr,
  output logic [32*FETCH_N-1:0]   inst_sram_rdata,
  output logic [FETCH_N-1:0]      inst_sram_valid,
  input  logic                    flush,
  input  logic                    longest_stall,
  output logic                    i_stall,
  output logic                    inst_req,
  output logic                    inst_wr,
  output logic [1:0]              inst_size,
  output logic [ADDR_W-1:0]       inst_addr,
  output logic [31:0]             inst_wdata,
  input  logic                    inst_addr_ok,
  input  logic [FETCH_N-1:0]      inst_data_ok,
  input  logic [32*FETCH_N-1:0]   inst_rdata
`ifdef I_BRIDGE_PERF_EN
  ,
  output logic [31:0]             perf_req_cnt,
  output logic [31:0]             perf_stall_cnt
`endif
);

  localparam int unsigned DATA_W = 32 * FETCH_N;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_DISCARD
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic                req_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   rdata_d;
  logic [FETCH_N-1:0]  valid_d;

  assign inst_wr    = 1'b0;
  assign inst_size  = 2'b10;
  assign inst_wdata = 32'd0;

  // Fetch is satisfied only once a beat is being held in DONE.
  assign i_stall = inst_sram_en & (state_q != S_DONE) & ~flush;

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      inst_req        <= 1'b0;
      inst_addr       <= '0;
      inst_sram_rdata <= '0;
      inst_sram_valid <= '0;
    end else begin
      state_q         <= state_d;
      inst_req        <= req_d;
      inst_addr       <= addr_d;
      inst_sram_rdata <= rdata_d;
      inst_sram_valid <= valid_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    addr_d  = inst_addr;
    rdata_d = inst_sram_rdata;
    valid_d = inst_sram_valid;

    unique case (state_q)
      S_IDLE: begin
        if (inst_sram_en && !flush) begin
          state_d = S_REQ;
          addr_d  = inst_sram_addr;
        end
      end
      S_REQ: begin
        if (inst_addr_ok) begin
          // A flush racing a zero-wait response has nothing left to wait for.
          if (flush) begin
            state_d = inst_data_ok[0] ? S_IDLE : S_DISCARD;
          end else if (inst_data_ok[0]) begin
            state_d = S_DONE;
            rdata_d = inst_rdata;
            valid_d = inst_data_ok;
          end else begin
            state_d = S_WAIT;
          end
        end else if (flush) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (inst_data_ok[0]) begin
          if (flush) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DONE;
            rdata_d = inst_rdata;
            valid_d = inst_data_ok;
          end
        end else if (flush) begin
          state_d = S_DISCARD;
        end
      end
      S_DONE: begin
        if (flush || !longest_stall) begin
          state_d = S_IDLE;
          valid_d = '0;
        end
      end
      S_DISCARD: begin
        if (inst_data_ok[0]) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    req_d = (state_d == S_REQ);
  end

`ifdef I_BRIDGE_PERF_EN
  // Saturating request and stall counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_req_cnt   <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (inst_req && inst_addr_ok && (perf_req_cnt != 32'hFFFF_FFFF)) begin
        perf_req_cnt <= perf_req_cnt + 32'd1;
      end
      if (i_stall && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_i_sram_like_bridge_nw.sv
// Bench for i_sram_like_bridge_nw: FETCH_N=2 and FETCH_N=4 instances share control
// stimulus and are checked every cycle against a transaction-level model.
module tb_i_sram_like_bridge_nw;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, en, flush, stall, addr_ok;
  logic [31:0]  sram_addr;
  logic [1:0]   dok2;
  logic [3:0]   dok4;
  logic [63:0]  rd2;
  logic [127:0] rd4;

  logic [63:0]  rdata2;
  logic [1:0]   valid2;
  logic         istall2, req2, wr2;
  logic [1:0]   size2;
  logic [31:0]  addr2, wdata2;

  logic [127:0] rdata4;
  logic [3:0]   valid4;
  logic         istall4, req4, wr4;
  logic [1:0]   size4;
  logic [31:0]  addr4, wdata4;

`ifdef I_BRIDGE_PERF_EN
  logic [31:0]  preq2, pstall2, preq4, pstall4;
`endif

  i_sram_like_bridge_nw #(.FETCH_N(2), .ADDR_W(32)) u_dut2 (
    .clk(clk), .rst(rst), .inst_sram_en(en), .inst_sram_addr(sram_addr),
    .inst_sram_rdata(rdata2), .inst_sram_valid(valid2), .flush(flush),
    .longest_stall(stall), .i_stall(istall2), .inst_req(req2), .inst_wr(wr2),
    .inst_size(size2), .inst_addr(addr2), .inst_wdata(wdata2),
    .inst_addr_ok(addr_ok), .inst_data_ok(dok2), .inst_rdata(rd2)
`ifdef I_BRIDGE_PERF_EN
    , .perf_req_cnt(preq2), .perf_stall_cnt(pstall2)
`endif
  );

  i_sram_like_bridge_nw #(.FETCH_N(4), .ADDR_W(32)) u_dut4 (
    .clk(clk), .rst(rst), .inst_sram_en(en), .inst_sram_addr(sram_addr),
    .inst_sram_rdata(rdata4), .inst_sram_valid(valid4), .flush(flush),
    .longest_stall(stall), .i_stall(istall4), .inst_req(req4), .inst_wr(wr4),
    .inst_size(size4), .inst_addr(addr4), .inst_wdata(wdata4),
    .inst_addr_ok(addr_ok), .inst_data_ok(dok4), .inst_rdata(rd4)
`ifdef I_BRIDGE_PERF_EN
    , .perf_req_cnt(preq4), .perf_stall_cnt(pstall4)
`endif
  );

  // Transaction-level reference: what the fetch is doing, not how the FSM encodes it.
  logic         m_pend, m_wait, m_drop, m_hold;
  logic [31:0]  m_addr;
  logic [63:0]  m_rd2;
  logic [127:0] m_rd4;
  logic [1:0]   m_v2;
  logic [3:0]   m_v4;
  logic [31:0]  m_preq, m_pstall;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic capture();
    m_rd2  = rd2;
    m_rd4  = rd4;
    m_v2   = dok2;
    m_v4   = dok4;
    m_hold = 1'b1;
  endtask

  // Inputs are driven at the negedge; outputs are checked 1 time unit later,
  // then the model advances across the coming posedge.
  task automatic step();
    logic exp_stall;
    #1;
    exp_stall = en & ~m_hold & ~flush;
    check("req2",    128'(req2),    128'(m_pend));
    check("req4",    128'(req4),    128'(m_pend));
    check("addr2",   128'(addr2),   128'(m_addr));
    check("addr4",   128'(addr4),   128'(m_addr));
    check("istall2", 128'(istall2), 128'(exp_stall));
    check("istall4", 128'(istall4), 128'(exp_stall));
    check("rdata2",  128'(rdata2),  128'(m_rd2));
    check("rdata4",  rdata4,        m_rd4);
    check("valid2",  128'(valid2),  128'(m_v2));
    check("valid4",  128'(valid4),  128'(m_v4));
    check("const2",  128'({wr2, size2, wdata2}), 128'({1'b0, 2'b10, 32'd0}));
    check("const4",  128'({wr4, size4, wdata4}), 128'({1'b0, 2'b10, 32'd0}));
`ifdef I_BRIDGE_PERF_EN
    check("preq2",   128'(preq2),   128'(m_preq));
    check("pstall2", 128'(pstall2), 128'(m_pstall));
    check("preq4",   128'(preq4),   128'(m_preq));
    check("pstall4", 128'(pstall4), 128'(m_pstall));
`endif
    if (rst) begin
      m_preq   = 32'd0;
      m_pstall = 32'd0;
    end else begin
      if (m_pend && addr_ok && m_preq != 32'hFFFF_FFFF) m_preq = m_preq + 32'd1;
      if (exp_stall && m_pstall != 32'hFFFF_FFFF) m_pstall = m_pstall + 32'd1;
    end

    if (rst) begin
      m_pend = 1'b0; m_wait = 1'b0; m_drop = 1'b0; m_hold = 1'b0;
      m_addr = 32'd0; m_rd2 = '0; m_rd4 = '0; m_v2 = '0; m_v4 = '0;
    end else if (m_pend) begin
      m_pend = 1'b0;
      if (!addr_ok) begin
        if (!flush) m_pend = 1'b1;
      end else if (flush) begin
        m_drop = ~dok2[0];
      end else if (dok2[0]) begin
        capture();
      end else begin
        m_wait = 1'b1;
      end
    end else if (m_wait) begin
      if (dok2[0]) begin
        m_wait = 1'b0;
        if (!flush) capture();
      end else if (flush) begin
        m_wait = 1'b0;
        m_drop = 1'b1;
      end
    end else if (m_drop) begin
      if (dok2[0]) m_drop = 1'b0;
    end else if (m_hold) begin
      if (flush || !stall) begin
        m_hold = 1'b0; m_v2 = '0; m_v4 = '0;
      end
    end else if (en && !flush) begin
      m_pend = 1'b1;
      m_addr = sram_addr;
    end
    @(negedge clk);
  endtask

  task automatic quiet();
    en = 1'b0; flush = 1'b0; stall = 1'b0; addr_ok = 1'b0;
    dok2 = '0; dok4 = '0;
  endtask

  initial begin
    rst = 1'b1; quiet(); sram_addr = 32'd0; rd2 = '0; rd4 = '0;
    m_pend = 1'b0; m_wait = 1'b0; m_drop = 1'b0; m_hold = 1'b0;
    m_addr = 32'd0; m_rd2 = '0; m_rd4 = '0; m_v2 = '0; m_v4 = '0;
    m_preq = 32'd0; m_pstall = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    step();
    rst = 1'b0;

    // Zero-wait fetch followed by a 5-cycle hold under stall.
    en = 1'b1; sram_addr = 32'hBFC0_0000;
    step();
    addr_ok = 1'b1; dok2 = 2'b11; dok4 = 4'b1111;
    rd2 = {32'h2, 32'h1}; rd4 = {32'h4, 32'h3, 32'h2, 32'h1};
    step();
    addr_ok = 1'b0; dok2 = '0; dok4 = '0; stall = 1'b1;
    #1;
    check("zw_istall", 128'(istall2), 128'(1'b0));
    check("zw_rdata",  128'(rdata2), 128'(64'h0000_0002_0000_0001));
    check("zw_valid",  128'(valid2), 128'(2'b11));
    en = 1'b0;
    repeat (5) step();
    stall = 1'b0;
    step();
    step();

    // Delayed response: addr_ok on the third REQ cycle, data_ok four cycles later.
    en = 1'b1; sram_addr = 32'h0000_1000;
    step();
    repeat (2) step();
    addr_ok = 1'b1; step(); addr_ok = 1'b0;
    repeat (3) step();
    dok2 = 2'b11; dok4 = 4'b1111; rd2 = 64'hAAAA_BBBB_CCCC_DDDD; rd4 = {64'h0, rd2};
    step();
    dok2 = '0; dok4 = '0;
    #1;
    check("dly_istall", 128'(istall2), 128'(1'b0));
    en = 1'b0;
    step();

    // Partial beat: only the low words are qualified.
    en = 1'b1; sram_addr = 32'h0000_2000;
    step();
    addr_ok = 1'b1; dok2 = 2'b01; dok4 = 4'b0011;
    rd2 = 64'h1111_2222_3333_4444; rd4 = {64'h5555_6666_7777_8888, rd2};
    step();
    addr_ok = 1'b0; dok2 = '0; dok4 = '0; en = 1'b0;
    #1;
    check("part_valid4", 128'(valid4), 128'(4'b0011));
    check("part_valid2", 128'(valid2), 128'(2'b01));
    step();

    // Flush in WAIT, late data dropped, next fetch uses the new address.
    en = 1'b1; sram_addr = 32'h0000_3000;
    step();
    addr_ok = 1'b1; step(); addr_ok = 1'b0;
    flush = 1'b1; step(); flush = 1'b0; en = 1'b0;
    step();
    dok2 = 2'b11; dok4 = 4'b1111; rd2 = 64'hDEAD_BEEF_DEAD_BEEF; rd4 = {2{rd2}};
    step();
    dok2 = '0; dok4 = '0;
    #1;
    check("fl_valid", 128'(valid2), 128'(2'b00));
    en = 1'b1; sram_addr = 32'h0000_4000;
    step();
    #1;
    check("fl_newreq",  128'(req2),  128'(1'b1));
    check("fl_newaddr", 128'(addr2), 128'(32'h0000_4000));
    step();
    addr_ok = 1'b1; dok2 = 2'b11; dok4 = 4'b1111; step();
    quiet(); step(); step();

    // Reset while waiting for data.
    en = 1'b1; sram_addr = 32'h0000_5000;
    step();
    addr_ok = 1'b1; step(); addr_ok = 1'b0;
    step();
    rst = 1'b1; step(); rst = 1'b0;
    #1;
    check("rst_req",   128'(req2),   128'(1'b0));
    check("rst_valid", 128'(valid2), 128'(2'b00));
    en = 1'b0;
    step();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      en        = ($urandom_range(0, 9) < 7);
      sram_addr = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      flush     = ($urandom_range(0, 9) == 0);
      stall     = ($urandom_range(0, 1) == 1);
      addr_ok   = ($urandom_range(0, 9) < 4);
      dok2      = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 4)};
      dok4      = {2'($urandom_range(0, 3)), dok2};
      rd2       = {$urandom(), $urandom()};
      rd4       = {$urandom(), $urandom(), rd2};
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
